// File: rtl/dual_bank_window_ctrl.sv
// Load/replay sequencer for the two-bank image-window BRAMs: streams a ROWS x COLS
// tile column-interleaved into both banks, then replays words while cycling sel_mux.
module dual_bank_window_ctrl #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 12,
  parameter int unsigned LANES      = 4,
  parameter int unsigned BANK1_BASE = 50,
  parameter int unsigned SEL_MAX    = 3,
  parameter int unsigned EXT_AW     = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  output logic [EXT_AW-1:0] ext_addr0,
  output logic [EXT_AW-1:0] ext_addr1,
  input  logic [7:0]        ext_data0,
  input  logic [7:0]        ext_data1,
  output logic              ena,
  output logic              wea,
  output logic [10:0]       addra,
  output logic [7:0]        dina0,
  output logic [7:0]        dina1,
  output logic              enb,
  output logic [8:0]        addrb,
  output logic [1:0]        sel_mux,
  output logic              window_valid,
  output logic              busy,
  output logic              complete
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned KW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0] R_LAST   = RW'(ROWS - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(COLS - 1);
  localparam logic [1:0]    SEL_LAST = 2'(SEL_MAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_LAST  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] w_q, w_d;
  logic [1:0]    sel_q, sel_d;
  logic          wr_q;
  logic [10:0]   addra_q;
  logic          rv_q;

  logic [EXT_AW-1:0] n_ext;
  logic [10:0]       a_col;

  // Element index and byte address are computed directly at their port widths,
  // which is the required truncation.
  assign n_ext = EXT_AW'(r_q) * EXT_AW'(COLS) + EXT_AW'(k_q);
  assign a_col = 11'(k_q) * 11'(LANES) + 11'(r_q);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    w_d     = w_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          r_d     = '0;
          k_d     = '0;
          w_d     = '0;
          sel_d   = '0;
        end
      end
      S_LOAD: begin
        if (k_q == K_LAST) begin
          k_d = '0;
          if (r_q == R_LAST) state_d = S_FLUSH;
          else               r_d     = r_q + 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_FLUSH: state_d = S_READ;
      S_READ: begin
        sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        if (w_q == K_LAST) state_d = S_LAST;
        else               w_d     = w_q + 1'b1;
      end
      S_LAST:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      k_q     <= '0;
      w_q     <= '0;
      sel_q   <= '0;
      wr_q    <= 1'b0;
      addra_q <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      w_q     <= w_d;
      sel_q   <= sel_d;
      // Write strobe and address trail the external read by one cycle to meet the data.
      wr_q    <= (state_q == S_LOAD);
      if (state_q == S_LOAD) addra_q <= a_col;
      rv_q    <= (state_q == S_READ);
    end
  end

  assign ext_addr0    = (state_q == S_LOAD) ? n_ext : '0;
  assign ext_addr1    = (state_q == S_LOAD) ? n_ext + EXT_AW'(BANK1_BASE) : '0;
  assign ena          = wr_q;
  assign wea          = wr_q;
  assign addra        = addra_q;
  assign dina0        = wr_q ? ext_data0 : '0;
  assign dina1        = wr_q ? ext_data1 : '0;
  assign enb          = (state_q == S_READ);
  assign addrb        = 9'(w_q);
  assign sel_mux      = sel_q;
  assign window_valid = rv_q;
  assign busy         = (state_q == S_LOAD) || (state_q == S_FLUSH) ||
                        (state_q == S_READ) || (state_q == S_LAST);
  assign complete     = (state_q == S_DONE);

endmodule

// File: tb/tb_dual_bank_window_ctrl.sv
// Scoreboard bench for dual_bank_window_ctrl with external-memory and BRAM models.
module tb_dual_bank_window_ctrl;

  localparam int ROWS = 4, COLS = 12, LANES = 4, BANK1_BASE = 50, SEL_MAX = 3, EXT_AW = 8;
  localparam int NEL = ROWS * COLS;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              start = 1'b0;
  logic [EXT_AW-1:0] ext_addr0, ext_addr1;
  logic [7:0]        ext_data0 = '0, ext_data1 = '0;
  logic              ena, wea, enb, window_valid, busy, complete;
  logic [10:0]       addra;
  logic [7:0]        dina0, dina1;
  logic [8:0]        addrb;
  logic [1:0]        sel_mux;

  always #5 CLK = ~CLK;

  dual_bank_window_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .LANES(LANES), .BANK1_BASE(BANK1_BASE),
    .SEL_MAX(SEL_MAX), .EXT_AW(EXT_AW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .start(start),
    .ext_addr0(ext_addr0), .ext_addr1(ext_addr1),
    .ext_data0(ext_data0), .ext_data1(ext_data1),
    .ena(ena), .wea(wea), .addra(addra), .dina0(dina0), .dina1(dina1),
    .enb(enb), .addrb(addrb), .sel_mux(sel_mux),
    .window_valid(window_valid), .busy(busy), .complete(complete)
  );

  // External memory: registered read, data one cycle after the address.
  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];
  always @(posedge CLK) begin
    ext_data0 <= mem0[ext_addr0];
    ext_data1 <= mem1[ext_addr1];
  end

  // Two BRAM banks: byte-wide write on port A, 32-bit little-endian word read on port B.
  logic [7:0]  bram0 [0:2047];
  logic [7:0]  bram1 [0:2047];
  logic [31:0] dout0 = '0, dout1 = '0;
  always @(posedge CLK) begin
    if (ena && wea) begin
      bram0[addra] <= dina0;
      bram1[addra] <= dina1;
    end
    if (enb) begin
      dout0 <= {bram0[{addrb, 2'd3}], bram0[{addrb, 2'd2}], bram0[{addrb, 2'd1}], bram0[{addrb, 2'd0}]};
      dout1 <= {bram1[{addrb, 2'd3}], bram1[{addrb, 2'd2}], bram1[{addrb, 2'd1}], bram1[{addrb, 2'd0}]};
    end
  end

  typedef struct packed { logic [10:0] a; logic [7:0] d0; logic [7:0] d1; } wr_t;
  typedef struct packed { logic [8:0] w; logic [1:0] s; } rd_t;
  typedef struct packed { logic [31:0] d0; logic [31:0] d1; } wd_t;

  wr_t wq[$];
  rd_t aq[$];
  wd_t dq[$];

  int checks = 0, passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compare every presented write, read issue and valid word against the queues.
  int   cyc = 0, wr_cnt = 0, first_wr = -1, last_wr = -1, cmp_rises = 0;
  logic prev_cmp = 1'b0, prev_busy = 1'b0;
  always @(negedge CLK) begin
    wr_t ew;
    rd_t ea;
    wd_t ed;
    cyc++;
    if (wea) begin
      if (wq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: addra=%0d dina0=%0d required no write", addra, dina0);
      end else begin
        ew = wq.pop_front();
        chk("addra", addra, ew.a);
        chk("dina0", dina0, ew.d0);
        chk("dina1", dina1, ew.d1);
        chk("ena_with_wea", ena, 1);
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
    end
    if (enb) begin
      if (aq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_read: addrb=%0d required no read", addrb);
      end else begin
        ea = aq.pop_front();
        chk("addrb", addrb, ea.w);
        chk("sel_mux", sel_mux, ea.s);
      end
    end
    if (window_valid) begin
      if (dq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: doutb0=%0h required no valid", dout0);
      end else begin
        ed = dq.pop_front();
        chk("doutb_bank0", dout0, ed.d0);
        chk("doutb_bank1", dout1, ed.d1);
      end
    end
    if (complete && !prev_cmp) begin
      cmp_rises++;
      chk("busy_before_complete", prev_busy, 1);
      chk("busy_at_complete", busy, 0);
    end
    prev_cmp  = complete;
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: element n of the tile lives at row n/COLS, column n%COLS; its byte
  // goes to column*LANES + row, so word w holds column w with row 0 in the low byte.
  task automatic push_run();
    wr_t e;
    rd_t a;
    wd_t d;
    for (int n = 0; n < NEL; n++) begin
      e.a  = 11'((n % COLS) * LANES + (n / COLS));
      e.d0 = mem0[n % 256];
      e.d1 = mem1[(BANK1_BASE + n) % 256];
      wq.push_back(e);
    end
    for (int w = 0; w < COLS; w++) begin
      a.w = 9'(w);
      a.s = 2'(w % (SEL_MAX + 1));
      aq.push_back(a);
      d = '0;
      for (int r = ROWS - 1; r >= 0; r--) begin
        d.d0 = {d.d0[23:0], mem0[(r * COLS + w) % 256]};
        d.d1 = {d.d1[23:0], mem1[(BANK1_BASE + r * COLS + w) % 256]};
      end
      dq.push_back(d);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic full_run(input string tag, input bit inject);
    int  start_w, rises0, t;
    bit  injected;
    push_run();
    start_w  = wr_cnt;
    rises0   = cmp_rises;
    first_wr = -1;
    injected = 1'b0;
    pulse_start();
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_complete_cleared"}, complete, 0);
    t = 0;
    while (!complete && t < 300) begin
      if (inject && !injected && enb && addrb == 9'd5) begin
        injected = 1'b1;
        pulse_start();
      end else begin
        tick();
      end
      t++;
    end
    chk({tag, "_complete_reached"}, complete, 1);
    chk({tag, "_write_count"}, wr_cnt - start_w, NEL);
    chk({tag, "_write_span"}, last_wr - first_wr, NEL - 1);
    repeat (4) tick();
    chk({tag, "_complete_held"}, complete, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_complete_rises"}, cmp_rises - rises0, 1);
    chk({tag, "_wq_drained"}, wq.size(), 0);
    chk({tag, "_aq_drained"}, aq.size(), 0);
    chk({tag, "_dq_drained"}, dq.size(), 0);
  endtask

  initial begin
    int t, start_w;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'(i);
      mem1[i] = 8'(i);
    end
    repeat (3) tick();
    chk("reset_outputs",
        {ext_addr0, ext_addr1, ena, wea, addra, dina0, dina1, enb, addrb, sel_mux,
         window_valid, busy, complete}, 0);
    RESET = 1'b0;
    repeat (20) tick();
    chk("idle_no_writes", wr_cnt, 0);
    chk("idle_busy", busy, 0);
    chk("idle_complete", complete, 0);

    full_run("run1", 1'b1);
    full_run("restart", 1'b0);

    // Abort mid-load at element 20.
    push_run();
    start_w = wr_cnt;
    pulse_start();
    t = 0;
    while (!(busy && ext_addr0 == 8'd20) && t < 100) begin
      tick();
      t++;
    end
    chk("abort_reached_n20", ext_addr0, 20);
    RESET = 1'b1;
    tick();
    chk("abort_wea", wea, 0);
    chk("abort_busy", busy, 0);
    chk("abort_complete", complete, 0);
    chk("abort_write_count", wr_cnt - start_w, 20);
    wq.delete();
    aq.delete();
    dq.delete();
    RESET = 1'b0;
    repeat (3) tick();
    chk("post_abort_idle_wea", wea, 0);

    full_run("after_abort", 1'b0);

    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
    full_run("random1", 1'b1);
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
    full_run("random2", 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
